// File: rtl/serial_paralelo.sv
// Receive-side serial-to-parallel converter: aligns to the idle COM symbol, declares the
// link active after a run of aligned COMs, then delivers every non-COM byte with a valid flag.
module serial_paralelo #(
    parameter logic [7:0] COM_SYMBOL   = 8'hBC,
    parameter int         ACTIVE_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ALIGNED = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    localparam logic [3:0] ACT_CNT = 4'(ACTIVE_COUNT);

    state_t     state_q;
    logic [7:0] sr_q;
    logic [2:0] bit_cnt_q;
    logic [3:0] com_cnt_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       active_q;

    logic [7:0] nxt_s;
    logic       com_hit_s;
    logic       byte_done_s;
    logic [3:0] com_cnt_inc_s;

    // Byte completed by the current edge and its classification
    always_comb begin
        nxt_s         = {sr_q[6:0], data_in};
        com_hit_s     = (nxt_s == COM_SYMBOL);
        byte_done_s   = (bit_cnt_q == 3'd7);
        com_cnt_inc_s = com_cnt_q + 4'd1;
    end

    // Alignment FSM with registered parallel outputs
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_SEARCH;
            sr_q      <= 8'd0;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            sr_q <= nxt_s;
            case (state_q)
                ST_SEARCH: begin
                    bit_cnt_q <= 3'd0;
                    if (com_hit_s) begin
                        com_cnt_q <= 4'd1;
                        if (ACT_CNT == 4'd1) begin
                            state_q  <= ST_ACTIVE;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= ST_ALIGNED;
                        end
                    end else begin
                        com_cnt_q <= 4'd0;
                    end
                end
                ST_ALIGNED: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (byte_done_s) begin
                        if (com_hit_s && (com_cnt_inc_s == ACT_CNT)) begin
                            state_q   <= ST_ACTIVE;
                            active_q  <= 1'b1;
                            com_cnt_q <= com_cnt_inc_s;
                        end else if (com_hit_s) begin
                            com_cnt_q <= com_cnt_inc_s;
                        end else begin
                            // Partial COM run is discarded; realign from scratch
                            state_q   <= ST_SEARCH;
                            com_cnt_q <= 4'd0;
                        end
                    end else begin
                        com_cnt_q <= com_cnt_q;
                    end
                end
                ST_ACTIVE: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    active_q  <= 1'b1;
                    if (byte_done_s) begin
                        if (com_hit_s) begin
                            valid_q <= 1'b0;
                        end else begin
                            data_q  <= nxt_s;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        valid_q <= valid_q;
                    end
                end
                default: begin
                    state_q   <= ST_SEARCH;
                    bit_cnt_q <= 3'd0;
                    com_cnt_q <= 4'd0;
                    valid_q   <= 1'b0;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: default ACTIVE_COUNT instance plus an ACTIVE_COUNT=1 instance.
module tb_serial_paralelo;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic [7:0] data_out1;
    logic       valid_out1;
    logic       active1;

    int total;
    int bad;

    serial_paralelo #(.COM_SYMBOL(8'hBC), .ACTIVE_COUNT(4)) dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    serial_paralelo #(.COM_SYMBOL(8'hBC), .ACTIVE_COUNT(1)) dut1 (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out1),
        .valid_out(valid_out1),
        .active   (active1)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one bit, let the edge sample it, return 1 time unit after the edge
    task automatic bit_tx(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bit_tx(v[i]);
    endtask

    // Send a COM byte; active must stay low until its LSB edge, then equal exp_act
    task automatic send_com_chk(input string tag, input logic exp_act);
        logic [7:0] v;
        v = 8'hBC;
        for (int i = 7; i >= 1; i--) bit_tx(v[i]);
        chk1({tag, "_pre"}, active, 1'b0);
        bit_tx(v[0]);
        chk1(tag, active, exp_act);
        chk1({tag, "_valid"}, valid_out, 1'b0);
    endtask

    // Send a byte in ACTIVE: old outputs held for the first 7 bits, new values after the LSB
    task automatic rx_byte(input string tag, input logic [7:0] v,
                           input logic [7:0] hold_d, input logic hold_v,
                           input logic [7:0] new_d, input logic new_v);
        for (int i = 7; i >= 1; i--) begin
            bit_tx(v[i]);
            chk8({tag, "_hold_data"}, data_out, hold_d);
            chk1({tag, "_hold_valid"}, valid_out, hold_v);
        end
        bit_tx(v[0]);
        chk8({tag, "_data"}, data_out, new_d);
        chk1({tag, "_valid"}, valid_out, new_v);
        chk1({tag, "_active"}, active, 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        for (int i = 0; i < cycles; i++) bit_tx(1'($urandom_range(0, 1)));
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] ca;
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        data_in = 1'b0;
        ca      = 8'hCA;
        #1;

        // Reset held with random serial input
        for (int i = 0; i < 16; i++) begin
            bit_tx(1'($urandom_range(0, 1)));
            chk8("rst_data", data_out, 8'h00);
            chk1("rst_valid", valid_out, 1'b0);
            chk1("rst_active", active, 1'b0);
            chk1("rst_active1", active1, 1'b0);
        end
        reset = 1'b1;

        send_byte(8'hFF);
        send_byte(8'hFF);
        chk1("ff_active", active, 1'b0);
        chk1("ff_active1", active1, 1'b0);
        chk1("ff_valid", valid_out, 1'b0);
        chk8("ff_data", data_out, 8'h00);

        // Alignment at a 3-bit offset
        bit_tx(1'b1);
        bit_tx(1'b0);
        bit_tx(1'b1);
        send_com_chk("align_com1", 1'b0);
        chk1("align_com1_active1", active1, 1'b1);
        send_com_chk("align_com2", 1'b0);
        send_com_chk("align_com3", 1'b0);
        send_com_chk("align_com4", 1'b1);
        chk8("align_data", data_out, 8'h00);

        // Data stream with an embedded COM
        rx_byte("d_ab", 8'hAB, 8'h00, 1'b0, 8'hAB, 1'b1);
        rx_byte("d_ca", 8'hCA, 8'hAB, 1'b1, 8'hCA, 1'b1);
        rx_byte("d_12", 8'h12, 8'hCA, 1'b1, 8'h12, 1'b1);
        rx_byte("d_bc", 8'hBC, 8'h12, 1'b1, 8'h12, 1'b0);
        rx_byte("d_fa", 8'hFA, 8'h12, 1'b0, 8'hFA, 1'b1);
        rx_byte("d_33", 8'h33, 8'hFA, 1'b1, 8'h33, 1'b1);

        // Broken COM run
        do_reset(3);
        chk1("brk_reset_active", active, 1'b0);
        send_com_chk("brk_a1", 1'b0);
        send_com_chk("brk_a2", 1'b0);
        send_byte(8'hDE);
        chk1("brk_de", active, 1'b0);
        send_com_chk("brk_b1", 1'b0);
        send_com_chk("brk_b2", 1'b0);
        send_com_chk("brk_b3", 1'b0);
        send_com_chk("brk_b4", 1'b1);
        rx_byte("brk_77", 8'h77, 8'h00, 1'b0, 8'h77, 1'b1);

        // Asynchronous reset between edges at bit 4 of 0xCA
        for (int i = 7; i >= 4; i--) bit_tx(ca[i]);
        chk8("ar_pre_data", data_out, 8'h77);
        chk1("ar_pre_valid", valid_out, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk8("ar_data", data_out, 8'h00);
        chk1("ar_valid", valid_out, 1'b0);
        chk1("ar_active", active, 1'b0);
        chk1("ar_active1", active1, 1'b0);
        @(posedge clk_32f);
        #1;
        do_reset(2);
        send_com_chk("ar_com1", 1'b0);
        send_com_chk("ar_com2", 1'b0);
        send_com_chk("ar_com3", 1'b0);
        send_com_chk("ar_com4", 1'b1);

        // ACTIVE_COUNT=1 instance activates on the first COM
        do_reset(2);
        send_byte(8'hFF);
        for (int i = 7; i >= 1; i--) bit_tx(ca[i] & 1'b0 | (i != 6 && i != 1 && i != 0 ? 1'b1 : 1'b0));
        chk1("p1_pre_active1", active1, 1'b0);
        bit_tx(1'b0);
        chk1("p1_active1", active1, 1'b1);
        chk1("p1_valid1", valid_out1, 1'b0);
        chk1("p1_active_default", active, 1'b0);
        send_byte(8'h5A);
        chk8("p1_data1", data_out1, 8'h5A);
        chk1("p1_valid1_after", valid_out1, 1'b1);
        chk1("p1_active1_after", active1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
